genie_conv_pipe: RTL
====================

// Module: genie_conv_pipe
// PURPOSE
//  Registered, full-throughput field converter for the interconnect: maps an input field
//  (e.g. local address/ID) to an output field through a parameter lookup table while data
//  passes alongside. Adds miss handling, miss statistics and a 2-entry skid buffer so it can
//  sit on long timing paths between fabric stages without losing a beat.
// PARAMETERS
//  WIDTH_DATA    0   width of carried data (0 legal: data path removed)
//  WIDTH_IN      1   width of input field
//  WIDTH_OUT     1   width of output field
//  N_ENTRIES     1   number of table pairs
//  IN_VALS       -   [N_ENTRIES][WIDTH_IN] input field values; must be unique
//  OUT_VALS      -   [N_ENTRIES][WIDTH_OUT] corresponding output values
//  MISS_MODE     MISS_PASS   MISS_PASS: forward miss with DEFAULT_OUT; MISS_DROP: consume, discard
//  DEFAULT_OUT   '0  output field driven on a passed miss
//  WIDTH_MISSCNT 16  width of saturating miss counter
// PORTS
//  clk           in   1           clock
//  reset         in   1           asynchronous reset, active-low (asserted at 0)
//  i_valid       in   1           input beat valid
//  o_ready       out  1           input may be accepted
//  i_data        in   WIDTH_DATA  input data
//  i_in          in   WIDTH_IN    input field
//  o_valid       out  1           output beat valid
//  i_ready       in   1           downstream ready
//  o_data        out  WIDTH_DATA  output data
//  o_out         out  WIDTH_OUT   converted field
//  o_miss        out  1           current output beat was a miss (MISS_PASS only; else 0)
//  o_err         out  1           sticky: at least one miss since reset/clear
//  o_miss_count  out  WIDTH_MISSCNT  saturating count of missed accepted beats
//  i_clr_err     in   1           synchronous clear of o_err and o_miss_count
// BEHAVIOUR
//  - Reset (reset=0, async): buffer EMPTY, o_valid=0, o_ready=0 while asserted, o_err=0,
//    o_miss_count=0, o_miss=0, o_out/o_data=0. In-flight beats discarded. o_ready=1 from
//    the first clock edge after deassertion.
//  - Accept = i_valid & o_ready; emit = o_valid & i_ready. Latency 1 cycle: beat accepted
//    at edge N appears on outputs after edge N. Throughput 1 beat/cycle sustained.
//  - Lookup: parallel compare i_in against all IN_VALS; result is OR of matching OUT_VALS
//    (one-hot, no priority chain). Miss = no match. Lookup done before the register.
//  - Buffer states (2 entries, main + skid): EMPTY -> ONE on accept; ONE -> ONE on
//    accept&emit; ONE -> TWO on accept&!emit; ONE -> EMPTY on emit&!accept;
//    TWO -> ONE on emit (no accept possible). o_ready = (state != TWO), registered only,
//    no combinational path i_ready -> o_ready. Order strictly FIFO; skid drains first.
//  - o_valid = (state != EMPTY). Outputs held stable while o_valid & !i_ready.
//  - MISS_DROP: missed beat still accepted (o_ready honoured), counted, never enters buffer.
//  - Miss counter increments by 1 per accepted miss, saturates at all-ones (no wrap).
//  - i_clr_err same cycle as accepted miss: result o_err=1, o_miss_count=1.
//  - Simulation assertion (disabled in reset): IN_VALS unique at elaboration;
//    o_valid & !i_ready => outputs unchanged next cycle.
// STRUCTURE
//  - genie_conv_pkg: miss_mode_e {MISS_PASS, MISS_DROP}; buffer state enum
//    {ST_EMPTY, ST_ONE, ST_TWO}.
//  - Sub-module genie_skid_buf #(WIDTH) carrying {data, out, miss}; conv logic and
//    counters in top level.
// TESTING  (table IN_VALS={3,7,9}, OUT_VALS={'hA,'hB,'hC}, WIDTH_MISSCNT=4)
//  1. Stream i_in=3,7,9, i_ready=1 -> o_out='hA,'hB,'hC one cycle later, back-to-back, o_miss=0.
//  2. i_ready=0 for 3 cycles, 3 beats offered -> 2 accepted, o_ready=0 on 3rd; release
//     -> beats emerge in order, none lost/duplicated.
//  3. MISS_PASS, i_in=5, DEFAULT_OUT='hF -> o_out='hF, o_miss=1, o_err=1, o_miss_count=1.
//  4. MISS_DROP, sequence 3,5,7 -> outputs 'hA,'hB only; o_miss_count=1.
//  5. 20 misses -> o_miss_count saturates at 15; i_clr_err with miss same cycle -> count=1.
//  6. reset asserted with buffer TWO -> o_valid=0 immediately, count/err 0, no stale beat.

Source files
------------

// File: rtl/genie_conv_pkg.sv
// Shared types for the field converter: miss handling modes and skid buffer occupancy.
package genie_conv_pkg;

  typedef enum logic {
    MISS_PASS,
    MISS_DROP
  } miss_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } buf_state_e;

endpackage

// File: rtl/genie_skid_buf.sv
// Two-entry FIFO skid buffer: the main entry drives the outputs and the skid entry holds the
// next beat. Ready comes from a flop, so there is no combinational path from downstream ready.
module genie_skid_buf
  import genie_conv_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_ready
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (i_push) begin
          main_d  = i_din;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (i_push && i_pop) begin
          main_d = i_din;
        end else if (i_push) begin
          skid_d  = i_din;
          state_d = ST_TWO;
        end else if (i_pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Upstream is stalled here, so only a pop can happen; the older beat leaves first.
        if (i_pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign o_dout  = main_q;
  assign o_valid = (state_q != ST_EMPTY);
  assign o_ready = ready_q;

endmodule

// File: rtl/genie_conv_pipe.sv
// Registered field converter: table lookup on the input field and miss flagging/counting,
// followed by a two-entry skid buffer that carries {data, converted field, miss}.
module genie_conv_pipe
  import genie_conv_pkg::*;
#(
  parameter int                                  WIDTH_DATA    = 0,
  parameter int                                  WIDTH_IN      = 1,
  parameter int                                  WIDTH_OUT     = 1,
  parameter int                                  N_ENTRIES     = 1,
  parameter logic [N_ENTRIES-1:0][WIDTH_IN-1:0]  IN_VALS       = '0,
  parameter logic [N_ENTRIES-1:0][WIDTH_OUT-1:0] OUT_VALS      = '0,
  parameter miss_mode_e                          MISS_MODE     = MISS_PASS,
  parameter logic [WIDTH_OUT-1:0]                DEFAULT_OUT   = '0,
  parameter int                                  WIDTH_MISSCNT = 16,
  localparam int                                 DW            = (WIDTH_DATA > 0) ? WIDTH_DATA : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DW-1:0]            i_data,
  input  logic [WIDTH_IN-1:0]      i_in,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DW-1:0]            o_data,
  output logic [WIDTH_OUT-1:0]     o_out,
  output logic                     o_miss,
  output logic                     o_err,
  output logic [WIDTH_MISSCNT-1:0] o_miss_count,
  input  logic                     i_clr_err
);

  localparam int PW = DW + WIDTH_OUT + 1;

  function automatic bit in_vals_dup();
    for (int i = 0; i < N_ENTRIES; i++)
      for (int j = i + 1; j < N_ENTRIES; j++)
        if (IN_VALS[i] == IN_VALS[j]) return 1'b1;
    return 1'b0;
  endfunction

  localparam bit IN_DUP = in_vals_dup();

  logic                     lut_hit;
  logic [WIDTH_OUT-1:0]     lut_out;
  logic                     miss;
  logic                     accept, emit, push, miss_acc;
  logic [PW-1:0]            din, dout;
  logic                     err_q, err_d;
  logic [WIDTH_MISSCNT-1:0] cnt_q, cnt_d;

  // Flat OR of matching entries; uniqueness of IN_VALS keeps the result one-hot.
  always_comb begin
    lut_hit = 1'b0;
    lut_out = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (i_in == IN_VALS[i]) begin
        lut_hit = 1'b1;
        lut_out = lut_out | OUT_VALS[i];
      end
    end
  end

  assign miss     = !lut_hit;
  assign accept   = i_valid && o_ready;
  assign emit     = o_valid && i_ready;
  assign push     = accept && !(MISS_MODE == MISS_DROP && miss);
  assign miss_acc = accept && miss;
  assign din      = {(WIDTH_DATA > 0) ? i_data : {DW{1'b0}},
                     miss ? DEFAULT_OUT : lut_out,
                     (MISS_MODE == MISS_PASS) && miss};

  genie_skid_buf #(
    .WIDTH(PW)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .i_push (push),
    .i_pop  (emit),
    .i_din  (din),
    .o_dout (dout),
    .o_valid(o_valid),
    .o_ready(o_ready)
  );

  assign {o_data, o_out, o_miss} = dout;

  // A clear coinciding with an accepted miss keeps that miss, so it is never lost.
  always_comb begin
    err_d = err_q || miss_acc;
    cnt_d = cnt_q;
    if (i_clr_err) begin
      err_d    = miss_acc;
      cnt_d    = '0;
      cnt_d[0] = miss_acc;
    end else if (miss_acc && cnt_q != {WIDTH_MISSCNT{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_err        = err_q;
  assign o_miss_count = cnt_q;

  a_in_vals_unique: assert property (@(posedge clk) disable iff (!reset) !IN_DUP);

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_out) && $stable(o_miss)));

endmodule
